alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - operand/opcode entry sequencer around an external sign-magnitude ALU
// Collects A, B and opcode from one shared bus, waits SETTLE cycles, then latches result and flags.
module alu_sequencer #(
  parameter int N      = 6,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         load,
  input  logic         clr,
  input  logic [N-1:0] alu_out,
  input  logic         alu_Z,
  input  logic         alu_O,
  input  logic         alu_Ca,
  input  logic         alu_Neg,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [3:0]   sel,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic [2:0]   state,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
  localparam logic [3:0] MAX_OP   = 4'd9;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] a_d, b_d, result_d;
  logic [3:0]   sel_d, flags_d;
  logic         done_d, err_d;

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = A;
    b_d      = B;
    sel_d    = sel;
    result_d = result;
    flags_d  = flags;
    done_d   = done;
    err_d    = err;
    // clr has priority over everything, including a coincident load
    if (clr) begin
      state_d = LOAD_A;
      cnt_d   = 4'd0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (load) begin
          a_d     = data_in;
          done_d  = 1'b0;
          state_d = LOAD_B;
        end
        LOAD_B: if (load) begin
          b_d     = data_in;
          state_d = LOAD_OP;
        end
        LOAD_OP: if (load) begin
          if (data_in[3:0] <= MAX_OP) begin
            sel_d   = data_in[3:0];
            err_d   = 1'b0;
            cnt_d   = 4'd0;
            state_d = EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
        EXEC: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            result_d = alu_out;
            flags_d  = {alu_Neg, alu_Z, alu_O, alu_Ca};
            done_d   = 1'b1;
            state_d  = SHOW;
          end
        end
        SHOW: if (load) begin
          done_d  = 1'b0;
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= 4'd0;
      A       <= '0;
      B       <= '0;
      sel     <= 4'd0;
      result  <= '0;
      flags   <= 4'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      A       <= a_d;
      B       <= b_d;
      sel     <= sel_d;
      result  <= result_d;
      flags   <= flags_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized scoreboard bench for alu_sequencer with a behavioural ALU attached
module tb_alu_sequencer;
  localparam int N      = 6;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] data_in = '0;
  logic [N-1:0] alu_out, A, B, result;
  logic         alu_Z, alu_O, alu_Ca, alu_Neg;
  logic [3:0]   sel, flags;
  logic [2:0]   state;
  logic         done, err;

  alu_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .clr(clr),
    .alu_out(alu_out), .alu_Z(alu_Z), .alu_O(alu_O), .alu_Ca(alu_Ca), .alu_Neg(alu_Neg),
    .A(A), .B(B), .sel(sel), .result(result), .flags(flags),
    .state(state), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // sign-magnitude ALU: returns {Neg, Z, O, Ca, result}
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
    int va, vb, r, m;
    logic [N-1:0] res;
    logic o, c, arith;
    va = a[N-1] ? -int'(a[N-2:0]) : int'(a[N-2:0]);
    vb = b[N-1] ? -int'(b[N-2:0]) : int'(b[N-2:0]);
    arith = 1'b1; r = 0; res = '0; o = 1'b0; c = 1'b0; m = 0;
    case (op)
      4'd0: r = va + vb;
      4'd1: r = va - vb;
      4'd2: begin arith = 1'b0; res = a & b; end
      4'd3: begin arith = 1'b0; res = a | b; end
      4'd4: begin arith = 1'b0; res = a ^ b; end
      4'd5: r = va;
      4'd6: r = vb;
      4'd7: r = -va;
      4'd8: r = va * 2;
      default: r = va / 2;
    endcase
    if (arith) begin
      m   = (r < 0) ? -r : r;
      o   = (m > (2 ** (N - 1) - 1));
      c   = m[N-1];
      res = {(r < 0) ? 1'b1 : 1'b0, m[N-2:0]};
    end
    return {res[N-1], res[N-2:0] == '0, o, c, res};
  endfunction

  assign {alu_Neg, alu_Z, alu_O, alu_Ca, alu_out} = alu_fn(A, B, sel);

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic [N-1:0] res;
    logic [3:0]   fl;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic [N-1:0] last_res = '0;
  logic [3:0]   last_fl = '0;
  logic [3:0]   last_sel = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_result", result, e.res);
        check("sb_flags", flags, e.fl);
        check("sb_A", A, e.a);
        check("sb_B", B, e.b);
        check("sb_sel", sel, e.op);
        check("sb_state_show", state, 3'd4);
        check("sb_latency", cyc, e.due);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] d);
    data_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_show();
    int k;
    k = 0;
    while (state !== 3'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (state !== 3'd4) check("show_timeout", state, 3'd4);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                         input int n_ill, input logic [3:0] ill0, input bit abort, input bit leave);
    logic [N-1:0] d;
    exp_t x;
    repeat ($urandom_range(0, 2)) tick();
    strobe(a);
    repeat ($urandom_range(0, 2)) tick();
    strobe(b);
    for (int i = 0; i < n_ill; i++) begin
      d = N'($urandom);
      d[3:0] = (i == 0) ? ill0 : 4'($urandom_range(10, 15));
      strobe(d);
      check("ill_err", err, 1'b1);
      check("ill_state", state, 3'd2);
      check("ill_sel_hold", sel, last_sel);
    end
    d = N'($urandom);
    d[3:0] = op;
    x.a = a; x.b = b; x.op = op;
    {x.fl, x.res} = alu_fn(a, b, op);
    x.due = cyc + 1 + SETTLE;
    sb.push_back(x);
    data_in = d;
    load = 1'b1;
    tick();
    last_sel = op;
    check("op_state_exec", state, 3'd3);
    check("op_err_clear", err, 1'b0);
    if (abort) begin
      clr = 1'b1;
      load = 1'b1;
      tick();
      clr = 1'b0;
      load = 1'b0;
      void'(sb.pop_back());
      check("abort_state", state, 3'd0);
      check("abort_done", done, 1'b0);
      check("abort_result_hold", result, last_res);
    end else begin
      // load activity during EXEC must be ignored
      repeat (SETTLE) begin
        load = 1'($urandom_range(0, 1));
        data_in = N'($urandom);
        tick();
      end
      load = 1'b0;
      wait_show();
      last_res = x.res;
      last_fl = x.fl;
      repeat ($urandom_range(0, 3)) tick();
      check("show_hold_result", result, last_res);
      if (leave) begin
        strobe(N'($urandom));
        check("leave_state", state, 3'd0);
        check("leave_done", done, 1'b0);
        check("leave_result_hold", result, last_res);
      end
    end
  endtask

  initial begin
    int k;
    logic [N-1:0] ra, rb, dd;
    exp_t x;
    repeat (2) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, 6'd0);
    check("rst_flags", flags, 4'd0);
    rst_n = 1'b1;

    run_txn(6'b000011, 6'b000010, 4'd0, 0, 4'd0, 1'b0, 1'b1);
    check("add_result", result, 6'b000101);
    check("add_flags", flags, 4'b0000);
    run_txn(6'b000010, 6'b000011, 4'd1, 0, 4'd0, 1'b0, 1'b1);
    check("sub_result", result, 6'b100001);
    check("sub_neg_flag", flags[3], 1'b1);
    run_txn(6'b000111, 6'b000001, 4'd2, 1, 4'b1100, 1'b0, 1'b1);
    run_txn(6'b100000, 6'b100000, 4'd6, 0, 4'd0, 1'b0, 1'b1);
    run_txn(6'b001010, 6'b000101, 4'd0, 0, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      run_txn(ra, rb, 4'($urandom_range(0, 9)), $urandom_range(0, 2), 4'($urandom_range(10, 15)),
              ($urandom_range(0, 4) == 0), 1'b1);
    end

    run_txn(6'b010001, 6'b000110, 4'd0, 0, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 3'd0);
    check("async_rst_A", A, 6'd0);
    check("async_rst_B", B, 6'd0);
    check("async_rst_sel", sel, 4'd0);
    check("async_rst_result", result, 6'd0);
    check("async_rst_flags", flags, 4'd0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sel = 4'd0;
    last_res = '0;
    dd = 6'b100101;
    x.a = dd; x.b = dd; x.op = dd[3:0];
    {x.fl, x.res} = alu_fn(dd, dd, dd[3:0]);
    x.due = cyc + 3 + SETTLE;
    sb.push_back(x);
    data_in = dd;
    load = 1'b1;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    wait_show();

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
